// File: rtl/uart_pkg.sv
// Shared definitions for the UART stream master: peripheral register map,
// STATUS bit positions and the state types of the master and its bus engine.
package uart_pkg;

    localparam logic [2:0] ADDR_BAUD_L      = 3'd0;
    localparam logic [2:0] ADDR_BAUD_H      = 3'd1;
    localparam logic [2:0] ADDR_STATUS      = 3'd2;
    localparam logic [2:0] ADDR_DATA        = 3'd3;
    localparam logic [2:0] ADDR_INT         = 3'd4;
    localparam logic [2:0] ADDR_INT_PENDING = 3'd5;

    localparam int STATUS_RX_AVAIL = 0;
    localparam int STATUS_TX_FULL  = 1;

    typedef enum logic [2:0] {
        ST_INIT_BL,
        ST_INIT_BH,
        ST_POLL,
        ST_RD_DATA,
        ST_WR_DATA
    } master_state_t;

    typedef enum logic [1:0] {
        TXN_IDLE,
        TXN_ACCESS,
        TXN_GAP
    } txn_state_t;

endpackage

// File: rtl/uart_bus_txn.sv
// Single peripheral bus transaction: holds enable with a stable command until
// bus_ready or timeout, then idles in GAP until the peer releases bus_ready.
module uart_bus_txn
    import uart_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       timeout,
    output logic       bus_enable,
    output logic       bus_wr_en,
    output logic [2:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ready,
    input  logic [7:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT);

    txn_state_t    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= TXN_IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            rdata      <= '0;
            bus_enable <= 1'b0;
            bus_wr_en  <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                TXN_IDLE: begin
                    // A leftover ready from before a reset must clear before enabling.
                    if (start && !bus_ready) begin
                        bus_enable <= 1'b1;
                        bus_wr_en  <= wr;
                        bus_addr   <= addr;
                        bus_wdata  <= wdata;
                        cnt        <= '0;
                        state      <= TXN_ACCESS;
                    end
                end
                TXN_ACCESS: begin
                    if (bus_ready) begin
                        rdata      <= bus_rdata;
                        bus_enable <= 1'b0;
                        done       <= 1'b1;
                        state      <= TXN_GAP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        bus_enable <= 1'b0;
                        done       <= 1'b1;
                        timeout    <= 1'b1;
                        state      <= TXN_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TXN_GAP: begin
                    if (!bus_ready) state <= TXN_IDLE;
                end
                default: state <= TXN_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_stream_master.sv
// Stream-to-UART bus master: programs the baud divisor, then polls STATUS and
// moves bytes between the TX/RX holding registers and the peripheral DATA register.
module uart_stream_master
    import uart_pkg::*;
#(
    parameter logic [15:0] BAUD_DIV = 16'd217,
    parameter int          TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       bus_enable,
    output logic       bus_wr_en,
    output logic [2:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ready,
    input  logic [7:0] bus_rdata,
    output logic       err,
    output logic       init_done
);

    master_state_t state;
    logic          go;
    logic          tx_full;
    logic [7:0]    tx_byte;
    logic          rx_full;

    logic          cmd_wr;
    logic [2:0]    cmd_addr;
    logic [7:0]    cmd_wdata;
    logic          txn_done;
    logic          txn_timeout;
    logic [7:0]    txn_rdata;

    assign tx_ready = !tx_full;
    assign rx_valid = rx_full;

    always_comb begin
        cmd_wr    = 1'b0;
        cmd_addr  = ADDR_STATUS;
        cmd_wdata = '0;
        case (state)
            ST_INIT_BL: begin cmd_wr = 1'b1; cmd_addr = ADDR_BAUD_L; cmd_wdata = BAUD_DIV[7:0];  end
            ST_INIT_BH: begin cmd_wr = 1'b1; cmd_addr = ADDR_BAUD_H; cmd_wdata = BAUD_DIV[15:8]; end
            ST_RD_DATA: cmd_addr = ADDR_DATA;
            ST_WR_DATA: begin cmd_wr = 1'b1; cmd_addr = ADDR_DATA; cmd_wdata = tx_byte; end
            default: ;
        endcase
    end

    // The engine spends at least one cycle in GAP after done, so the state
    // updated on the cycle after done is what the next transaction captures.
    uart_bus_txn #(.TIMEOUT(TIMEOUT)) u_txn (
        .clk        (clk),
        .rst        (rst),
        .start      (go),
        .wr         (cmd_wr),
        .addr       (cmd_addr),
        .wdata      (cmd_wdata),
        .done       (txn_done),
        .rdata      (txn_rdata),
        .timeout    (txn_timeout),
        .bus_enable (bus_enable),
        .bus_wr_en  (bus_wr_en),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_INIT_BL;
            go        <= 1'b0;
            init_done <= 1'b0;
            err       <= 1'b0;
            tx_full   <= 1'b0;
            tx_byte   <= '0;
            rx_full   <= 1'b0;
            rx_data   <= '0;
        end else begin
            go <= 1'b1;
            if (tx_valid && !tx_full) begin
                tx_full <= 1'b1;
                tx_byte <= tx_data;
            end
            if (rx_full && rx_ready) rx_full <= 1'b0;
            if (txn_done) begin
                if (txn_timeout) err <= 1'b1;
                case (state)
                    ST_INIT_BL: state <= ST_INIT_BH;
                    ST_INIT_BH: begin
                        state     <= ST_POLL;
                        init_done <= 1'b1;
                    end
                    ST_POLL: begin
                        if (!txn_timeout && txn_rdata[STATUS_RX_AVAIL] && !rx_full)
                            state <= ST_RD_DATA;
                        else if (!txn_timeout && tx_full && !txn_rdata[STATUS_TX_FULL])
                            state <= ST_WR_DATA;
                        else
                            state <= ST_POLL;
                    end
                    ST_RD_DATA: begin
                        if (!txn_timeout) begin
                            rx_data <= txn_rdata;
                            rx_full <= 1'b1;
                        end
                        state <= ST_POLL;
                    end
                    ST_WR_DATA: begin
                        if (!txn_timeout) tx_full <= 1'b0;
                        state <= ST_POLL;
                    end
                    default: state <= ST_INIT_BL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_stream_master.sv
// Bench for uart_stream_master: behavioural UART peripheral with its own RX byte
// queue and TX capture log, plus stream-level scoreboards and bus protocol monitors.
module tb_uart_stream_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       bus_enable;
    logic       bus_wr_en;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ready = 1'b0;
    logic [7:0] bus_rdata = '0;
    logic       err;
    logic       init_done;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
    } op_t;

    op_t        ops[$];
    logic [7:0] rxq[$];
    logic [7:0] txlog[$];
    logic [7:0] rx_got[$];

    logic tx_busy = 1'b0;
    logic rx_visible = 1'b1;
    logic hang_wr = 1'b0;
    int   viol = 0;
    int   en_cnt = 0;
    int   last_en_len = 0;
    int   wr_starts = 0;
    logic en_q = 1'b0, rdy_q = 1'b0, wr_q = 1'b0;
    logic [2:0] addr_q = '0;
    logic [7:0] wd_q = '0;
    logic fresh_rx = 1'b0, st_txfull = 1'b0;

    uart_stream_master #(.BAUD_DIV(16'h1234), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .bus_enable (bus_enable),
        .bus_wr_en  (bus_wr_en),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata),
        .err        (err),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    // Peripheral model: ready two cycles after enable rises, released once enable is seen low.
    always @(posedge clk) begin
        if (bus_enable && !en_q && rdy_q) viol++;
        if (bus_enable && en_q && (bus_addr !== addr_q || bus_wr_en !== wr_q || bus_wdata !== wd_q)) viol++;
        if (bus_enable && !en_q && bus_wr_en && bus_addr == 3'd3) wr_starts++;
        if (!bus_enable) begin
            if (en_cnt != 0) last_en_len = en_cnt;
            en_cnt = 0;
            bus_ready <= 1'b0;
        end else begin
            if (bus_ready) begin
                ops.push_back({bus_wr_en, bus_addr, bus_wr_en ? bus_wdata : bus_rdata});
                if (!bus_wr_en && bus_addr == 3'd2) begin
                    fresh_rx  = bus_rdata[0];
                    st_txfull = bus_rdata[1];
                end
                if (!bus_wr_en && bus_addr == 3'd3) begin
                    if (!fresh_rx) viol++;
                    fresh_rx = 1'b0;
                    if (rxq.size() != 0) void'(rxq.pop_front());
                end
                if (bus_wr_en && bus_addr == 3'd3) begin
                    if (st_txfull) viol++;
                    else txlog.push_back(bus_wdata);
                end
            end else if (en_cnt >= 1 && !(hang_wr && bus_wr_en && bus_addr == 3'd3)) begin
                bus_ready <= 1'b1;
                if (bus_addr == 3'd2)
                    bus_rdata <= {6'b0, tx_busy, rx_visible && rxq.size() != 0};
                else
                    bus_rdata <= (rxq.size() != 0) ? rxq[0] : 8'h00;
            end
            en_cnt++;
        end
        en_q   = bus_enable;
        rdy_q  = bus_ready;
        wr_q   = bus_wr_en;
        addr_q = bus_addr;
        wd_q   = bus_wdata;
    end

    always @(posedge clk) begin
        if (rst && rx_valid && rx_ready) rx_got.push_back(rx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic int count_data(input logic wr, input int from);
        int n = 0;
        for (int i = from; i < ops.size(); i++)
            if (ops[i].wr == wr && ops[i].addr == 3'd3) n++;
        return n;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        logic got = 1'b0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (tx_ready) begin
                got = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL tx_accept: byte %02h not accepted, tx_ready=%b required 1", b, tx_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (tx_ready !== 1'b1)   begin fails++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0)   begin fails++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
        checks++; if (bus_enable !== 1'b0) begin fails++; $display("FAIL reset_enable: got %b required 0", bus_enable); end
        checks++; if ({bus_wr_en, bus_addr, bus_wdata} !== 12'h000) begin
            fails++; $display("FAIL reset_bus: got %h required 000", {bus_wr_en, bus_addr, bus_wdata});
        end
        checks++; if ({err, init_done} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b required 00", {err, init_done}); end
    endtask

    task automatic test_init();
        int n = 0;
        @(negedge clk);
        rst = 1'b1;
        while (ops.size() < 5 && n < 400) begin @(negedge clk); n++; end
        checks++; if (ops.size() < 5) begin fails++; $display("FAIL init_ops: got %0d ops required 5", ops.size()); end
        checks++; if (ops[0] !== {1'b1, 3'd0, 8'h34}) begin fails++; $display("FAIL init_baud_l: got %h required 834", ops[0]); end
        checks++; if (ops[1] !== {1'b1, 3'd1, 8'h12}) begin fails++; $display("FAIL init_baud_h: got %h required 912", ops[1]); end
        checks++; if (init_done !== 1'b1) begin fails++; $display("FAIL init_done: got %b required 1", init_done); end
        for (int i = 2; i < 5; i++) begin
            checks++;
            if ({ops[i].wr, ops[i].addr} !== 4'b0010) begin
                fails++; $display("FAIL init_poll%0d: got wr/addr %b required 0010", i, {ops[i].wr, ops[i].addr});
            end
        end
    endtask

    task automatic test_tx();
        int base;
        int n;
        logic [7:0] exp[$];
        base = txlog.size();
        send_byte(8'h41);
        n = 0; while (txlog.size() <= base && n < 200) begin @(negedge clk); n++; end
        checks++; if (txlog.size() != base + 1 || txlog[base] !== 8'h41) begin
            fails++; $display("FAIL tx_41: got %0d bytes, first %h required 41", txlog.size() - base, txlog[base]);
        end
        repeat (2) @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL tx_ready_after: got %b required 1", tx_ready); end

        tx_busy = 1'b1;
        @(negedge clk);
        base = txlog.size();
        send_byte(8'h99);
        repeat (60) @(negedge clk);
        checks++; if (txlog.size() != base) begin fails++; $display("FAIL tx_blocked: got %0d writes required 0", txlog.size() - base); end
        checks++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL tx_held: tx_ready got %b required 0", tx_ready); end
        tx_busy = 1'b0;
        n = 0; while (txlog.size() <= base && n < 200) begin @(negedge clk); n++; end
        checks++; if (txlog[base] !== 8'h99) begin fails++; $display("FAIL tx_unblocked: got %h required 99", txlog[base]); end

        base = txlog.size();
        for (int i = 0; i < 5; i++) begin
            exp.push_back(8'($urandom));
            send_byte(exp[i]);
        end
        n = 0; while (txlog.size() < base + 5 && n < 600) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (txlog[base + i] !== exp[i]) begin fails++; $display("FAIL tx_rand%0d: got %h required %h", i, txlog[base + i], exp[i]); end
        end
    endtask

    task automatic test_rx();
        int mark;
        int base;
        int n;
        rx_ready = 1'b0;
        base = rx_got.size();
        mark = ops.size();
        rxq.push_back(8'h5A);
        n = 0; while (!rx_valid && n < 200) begin @(negedge clk); n++; end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            fails++; $display("FAIL rx_first: got valid=%b data=%h required 1/5a", rx_valid, rx_data);
        end
        rxq.push_back(8'h77);
        repeat (50) @(negedge clk);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
            fails++; $display("FAIL rx_held: got valid=%b data=%h required 1/5a", rx_valid, rx_data);
        end
        checks++; if (count_data(1'b0, mark) != 1) begin fails++; $display("FAIL rx_no_extra_read: got %0d reads required 1", count_data(1'b0, mark)); end
        rx_ready = 1'b1;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rx_drop: rx_valid got %b required 0", rx_valid); end
        n = 0; while (rx_got.size() < base + 2 && n < 200) begin @(negedge clk); n++; end
        checks++; if (rx_got[base] !== 8'h5A || rx_got[base + 1] !== 8'h77) begin
            fails++; $display("FAIL rx_order: got %h %h required 5a 77", rx_got[base], rx_got[base + 1]);
        end
    endtask

    task automatic test_priority();
        int mark;
        int base_rx;
        int base_tx;
        int n;
        int first_data;
        rx_ready = 1'b1;
        base_rx = rx_got.size();
        base_tx = txlog.size();
        tx_busy = 1'b1;
        rx_visible = 1'b0;
        rxq.push_back(8'hE1);
        send_byte(8'h3C);
        repeat (10) @(negedge clk);
        mark = ops.size();
        tx_busy = 1'b0;
        rx_visible = 1'b1;
        n = 0; while ((rx_got.size() <= base_rx || txlog.size() <= base_tx) && n < 300) begin @(negedge clk); n++; end
        first_data = -1;
        for (int i = mark; i < ops.size(); i++)
            if (first_data < 0 && ops[i].addr == 3'd3) first_data = i;
        checks++; if (first_data < 0 || ops[first_data].wr !== 1'b0) begin
            fails++; $display("FAIL prio_rd_first: first DATA op index %0d wr=%b required read", first_data, ops[first_data].wr);
        end
        checks++; if (rx_got[base_rx] !== 8'hE1 || txlog[base_tx] !== 8'h3C) begin
            fails++; $display("FAIL prio_bytes: got rx %h tx %h required e1 3c", rx_got[base_rx], txlog[base_tx]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rx[$];
        logic [7:0] exp_tx[$];
        int base_rx;
        int base_tx;
        int n;
        base_rx = rx_got.size();
        base_tx = txlog.size();
        for (int i = 0; i < 4; i++) begin
            exp_rx.push_back(8'($urandom));
            rxq.push_back(exp_rx[i]);
        end
        for (int i = 0; i < 4; i++) begin
            exp_tx.push_back(8'($urandom));
            rx_ready = 1'($urandom_range(0, 1));
            send_byte(exp_tx[i]);
        end
        n = 0;
        while ((rx_got.size() < base_rx + 4 || txlog.size() < base_tx + 4) && n < 1500) begin
            @(negedge clk);
            rx_ready = 1'($urandom_range(0, 1));
            n++;
        end
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_got[base_rx + i] !== exp_rx[i] || txlog[base_tx + i] !== exp_tx[i]) begin
                fails++;
                $display("FAIL b2b%0d: got rx %h tx %h required rx %h tx %h", i, rx_got[base_rx + i], txlog[base_tx + i], exp_rx[i], exp_tx[i]);
            end
        end
        checks++; if (viol != 0) begin fails++; $display("FAIL bus_protocol: got %0d violations required 0", viol); end
    endtask

    task automatic test_timeout();
        int base;
        int s0;
        int n;
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL err_clean: got %b required 0", err); end
        hang_wr = 1'b1;
        base = txlog.size();
        s0 = wr_starts;
        send_byte(8'hC3);
        n = 0; while (err !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL to_err: got %b required 1", err); end
        checks++; if (last_en_len != 16) begin fails++; $display("FAIL to_len: enable high %0d cycles required 16", last_en_len); end
        checks++; if (tx_ready !== 1'b0 || txlog.size() != base) begin
            fails++; $display("FAIL to_kept: tx_ready=%b writes=%0d required 0/0", tx_ready, txlog.size() - base);
        end
        n = 0; while (wr_starts < s0 + 2 && n < 300) begin @(negedge clk); n++; end
        checks++; if (wr_starts < s0 + 2) begin fails++; $display("FAIL to_retry: got %0d attempts required 2", wr_starts - s0); end
        hang_wr = 1'b0;
        n = 0; while (txlog.size() <= base && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++; if (txlog[base] !== 8'hC3 || tx_ready !== 1'b1) begin
            fails++; $display("FAIL to_recover: got byte %h tx_ready %b required c3/1", txlog[base], tx_ready);
        end
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b required 1", err); end
    endtask

    task automatic test_reset_mid();
        int mark;
        int n;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus_enable) break;
        end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus_enable !== 1'b0) begin fails++; $display("FAIL rst_async_enable: got %b required 0", bus_enable); end
        checks++; if ({err, init_done, tx_ready, rx_valid} !== 4'b0010) begin
            fails++; $display("FAIL rst_async_flags: got %b required 0010", {err, init_done, tx_ready, rx_valid});
        end
        repeat (3) @(negedge clk);
        mark = ops.size();
        rst = 1'b1;
        n = 0; while (ops.size() < mark + 2 && n < 200) begin @(negedge clk); n++; end
        checks++; if (ops[mark] !== {1'b1, 3'd0, 8'h34} || ops[mark + 1] !== {1'b1, 3'd1, 8'h12}) begin
            fails++; $display("FAIL rst_restart: got %h %h required 834 912", ops[mark], ops[mark + 1]);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_tx();
        test_rx();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
